// File: rtl/pipe_pkg.sv
// Shared pipeline memory-stage definitions: FSM encoding, alignment mask and
// default access parameters used by the data and instruction memory units.
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0]  WORD_ALIGN_MASK   = 2'b11;
  localparam int unsigned DEFAULT_TIMEOUT   = 16;
  localparam logic [31:0] DEFAULT_ERR_RDATA = 32'h0000_0000;

  function automatic logic is_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb & WORD_ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// 8-bit wait counter for memory handshakes; expired flags the last cycle an
// ack may still arrive before the access is abandoned.
module mem_timeout_ctr #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= 8'd0;
    end else if (clr) begin
      count_reg <= 8'd0;
    end else if (en && count_reg != 8'hFF) begin
      count_reg <= count_reg + 8'd1;
    end
  end

  assign expired = (count_reg == LAST);

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: one req/ack transaction per instruction,
// stalling the upstream pipeline until the access completes or times out.
module mem_access_unit
  import pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT   = DEFAULT_TIMEOUT,
  parameter logic [31:0] ERR_RDATA = DEFAULT_ERR_RDATA
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] Addr_i,
  input  logic [31:0] WrData_i,
  output logic [31:0] Read_Data_o,
  output logic        stall_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  state_t state_reg, state_next;

  logic        acc;
  logic        aligned;
  logic        stall;
  logic        issue;
  logic        misalign;
  logic        finish_ok;
  logic        abort;
  logic        ctr_en;
  logic        ctr_clr;
  logic        ctr_expired;

  logic [31:0] read_data_reg;
  logic        err_reg;
  logic        req_reg;
  logic        we_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;

  assign acc     = MemRead_i | MemWrite_i;
  assign aligned = is_aligned(Addr_i[1:0]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // DONE ignores acc: EX/MEM still holds the instruction just serviced.
  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    issue      = 1'b0;
    misalign   = 1'b0;
    finish_ok  = 1'b0;
    abort      = 1'b0;
    ctr_en     = 1'b0;
    ctr_clr    = 1'b1;
    case (state_reg)
      IDLE: begin
        if (acc) begin
          if (aligned) begin
            issue      = 1'b1;
            stall      = 1'b1;
            state_next = REQ;
          end else begin
            misalign = 1'b1;
          end
        end
      end
      REQ: begin
        stall   = 1'b1;
        ctr_en  = 1'b1;
        ctr_clr = 1'b0;
        if (mem_ack_i) begin
          finish_ok  = 1'b1;
          ctr_clr    = 1'b1;
          state_next = DONE;
        end else if (ctr_expired) begin
          abort      = 1'b1;
          ctr_clr    = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  mem_timeout_ctr #(
    .LIMIT(TIMEOUT)
  ) u_timeout_ctr (
    .clk    (clk_i),
    .rst    (rst_i),
    .clr    (ctr_clr),
    .en     (ctr_en),
    .expired(ctr_expired)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      read_data_reg <= 32'd0;
      err_reg       <= 1'b0;
      req_reg       <= 1'b0;
      we_reg        <= 1'b0;
      addr_reg      <= 32'd0;
      wdata_reg     <= 32'd0;
    end else begin
      if (issue) begin
        req_reg   <= 1'b1;
        we_reg    <= MemWrite_i;
        addr_reg  <= {Addr_i[31:2], 2'b00};
        wdata_reg <= WrData_i;
      end
      if (finish_ok || abort) begin
        req_reg <= 1'b0;
      end
      if (finish_ok && !we_reg) begin
        read_data_reg <= mem_rdata_i;
      end
      if (abort) begin
        err_reg <= 1'b1;
        if (!we_reg) begin
          read_data_reg <= ERR_RDATA;
        end
      end
      // A misaligned access with both strobes set counts as a store.
      if (misalign) begin
        err_reg <= 1'b1;
        if (MemRead_i && !MemWrite_i) begin
          read_data_reg <= ERR_RDATA;
        end
      end
    end
  end

  // The stall is released the moment reset asserts, not at the next edge.
  assign stall_o     = stall & ~rst_i;
  assign Read_Data_o = read_data_reg;
  assign err_o       = err_reg;
  assign mem_req_o   = req_reg;
  assign mem_we_o    = we_reg;
  assign mem_addr_o  = addr_reg;
  assign mem_wdata_o = wdata_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized
// accesses against a transaction-level model of stall, request and read data.
module tb_mem_access_unit;

  localparam int          TO   = 4;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        MemRead_i, MemWrite_i;
  logic [31:0] Addr_i, WrData_i;
  logic [31:0] Read_Data_o;
  logic        stall_o, err_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd_exp;
  logic        err_exp;
  int          last_stalls;
  int          last_rises;

  mem_access_unit #(
    .TIMEOUT  (TO),
    .ERR_RDATA(ERRD)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .MemRead_i  (MemRead_i),
    .MemWrite_i (MemWrite_i),
    .Addr_i     (Addr_i),
    .WrData_i   (WrData_i),
    .Read_Data_o(Read_Data_o),
    .stall_o    (stall_o),
    .err_o      (err_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ack_i  (mem_ack_i),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // One instruction held on the EX/MEM inputs from its detect cycle through DONE.
  // The memory acks ack_delay cycles into the request (negative = never).
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input int ack_delay,
                            input logic [31:0] rdata, input string tag);
    bit acc       = rd | wr;
    bit is_write  = wr;
    bit is_load   = rd & ~wr;
    bit misal     = acc && (addr[1:0] != 2'b00);
    bit timed_out = (ack_delay < 0) || (ack_delay > TO - 1);
    int req_cycles  = timed_out ? TO : ack_delay + 1;
    int total_stall = (acc && !misal) ? req_cycles + 1 : 0;
    int last_t      = (acc && !misal) ? total_stall : 0;
    int stalls = 0;
    int rises  = 0;
    logic prev_req = 1'b0;
    bit exp_stall, exp_req;
    for (int t = 0; t <= last_t; t++) begin
      @(negedge clk_i);
      MemRead_i  = rd;
      MemWrite_i = wr;
      Addr_i     = addr;
      WrData_i   = wdata;
      if (t >= 1 && t < total_stall && (t - 1) == ack_delay) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = rdata;
      end else begin
        mem_ack_i   = (t == 0 || t == last_t) ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata_i = $urandom;
      end
      #1;
      exp_stall = (t < total_stall);
      exp_req   = (t >= 1) && (t < total_stall);
      checks++;
      if (stall_o !== exp_stall) begin
        errors++;
        $display("FAIL %s stall t=%0d got %0b want %0b", tag, t, stall_o, exp_stall);
      end
      checks++;
      if (mem_req_o !== exp_req) begin
        errors++;
        $display("FAIL %s req t=%0d got %0b want %0b", tag, t, mem_req_o, exp_req);
      end
      checks++;
      if (Read_Data_o !== rd_exp) begin
        errors++;
        $display("FAIL %s rdata t=%0d got %h want %h", tag, t, Read_Data_o, rd_exp);
      end
      checks++;
      if (err_o !== err_exp) begin
        errors++;
        $display("FAIL %s err t=%0d got %0b want %0b", tag, t, err_o, err_exp);
      end
      if (exp_req) begin
        checks++;
        if (mem_we_o !== is_write || mem_addr_o !== addr || mem_wdata_o !== wdata) begin
          errors++;
          $display("FAIL %s bus t=%0d got we=%0b addr=%h wdata=%h want we=%0b addr=%h wdata=%h",
                   tag, t, mem_we_o, mem_addr_o, mem_wdata_o, is_write, addr, wdata);
        end
      end
      if (stall_o) stalls++;
      if (mem_req_o && !prev_req) rises++;
      prev_req = mem_req_o;
      if (misal) begin
        err_exp = 1'b1;
        if (is_load) rd_exp = ERRD;
      end
      if (acc && !misal && t == total_stall - 1) begin
        if (timed_out) begin
          err_exp = 1'b1;
          if (is_load) rd_exp = ERRD;
        end else if (is_load) begin
          rd_exp = rdata;
        end
      end
    end
    last_stalls = stalls;
    last_rises  = rises;
    $display("txn %s rd=%0b wr=%0b addr=%h delay=%0d stalls=%0d reqs=%0d rdata_out=%h",
             tag, rd, wr, addr, ack_delay, stalls, rises, Read_Data_o);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    MemRead_i = 1'b0; MemWrite_i = 1'b0; Addr_i = '0; WrData_i = '0;
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    repeat (2) @(negedge clk_i);
    #1;
    checks++;
    if (Read_Data_o !== 32'd0 || stall_o !== 1'b0 || err_o !== 1'b0 || mem_req_o !== 1'b0 ||
        mem_we_o !== 1'b0 || mem_addr_o !== 32'd0 || mem_wdata_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_state got rdata=%h stall=%0b err=%0b req=%0b we=%0b addr=%h wdata=%h want all zero",
               Read_Data_o, stall_o, err_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    rd_exp = 32'd0;
    err_exp = 1'b0;
  endtask

  task automatic test_load();
    run_access(1'b1, 1'b0, 32'h100, 32'h5555_AAAA, 1, 32'hCAFE_BABE, "load");
    checks++;
    if (last_stalls != 3 || last_rises != 1) begin
      errors++;
      $display("FAIL load_shape got stalls=%0d reqs=%0d want stalls=3 reqs=1", last_stalls, last_rises);
    end
    checks++;
    if (Read_Data_o !== 32'hCAFE_BABE) begin
      errors++;
      $display("FAIL load_data got %h want cafebabe", Read_Data_o);
    end
  endtask

  task automatic test_store();
    run_access(1'b0, 1'b1, 32'h204, 32'h1234_5678, 0, 32'h0BAD_F00D, "store");
    checks++;
    if (last_stalls != 2 || last_rises != 1) begin
      errors++;
      $display("FAIL store_shape got stalls=%0d reqs=%0d want stalls=2 reqs=1", last_stalls, last_rises);
    end
    checks++;
    if (Read_Data_o !== 32'hCAFE_BABE) begin
      errors++;
      $display("FAIL store_keeps_rdata got %h want cafebabe", Read_Data_o);
    end
  endtask

  task automatic test_misaligned();
    run_access(1'b1, 1'b0, 32'h102, 32'h0, 0, 32'h7777_7777, "misaligned");
    checks++;
    if (last_stalls != 0 || last_rises != 0) begin
      errors++;
      $display("FAIL misaligned_shape got stalls=%0d reqs=%0d want 0 and 0", last_stalls, last_rises);
    end
    run_access(1'b0, 1'b0, 32'h0, 32'h0, -1, 32'h0, "idle");
    checks++;
    if (err_o !== 1'b1 || Read_Data_o !== ERRD) begin
      errors++;
      $display("FAIL misaligned_result got err=%0b rdata=%h want err=1 rdata=%h", err_o, Read_Data_o, ERRD);
    end
  endtask

  task automatic test_timeout();
    run_access(1'b1, 1'b0, 32'h40, 32'h0, 0, 32'h1111_2222, "pre_timeout");
    run_access(1'b1, 1'b0, 32'h300, 32'h0, -1, 32'h0, "timeout");
    checks++;
    if (last_stalls != TO + 1 || last_rises != 1) begin
      errors++;
      $display("FAIL timeout_shape got stalls=%0d reqs=%0d want stalls=%0d reqs=1", last_stalls, last_rises, TO + 1);
    end
    checks++;
    if (Read_Data_o !== ERRD || err_o !== 1'b1) begin
      errors++;
      $display("FAIL timeout_result got rdata=%h err=%0b want rdata=%h err=1", Read_Data_o, err_o, ERRD);
    end
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, 1'b0, 32'h10, 32'h0, 0, 32'hA0A0_0001, "b2b_first");
    checks++;
    if (last_rises != 1 || Read_Data_o !== 32'hA0A0_0001) begin
      errors++;
      $display("FAIL b2b_first got reqs=%0d rdata=%h want reqs=1 rdata=a0a00001", last_rises, Read_Data_o);
    end
    run_access(1'b1, 1'b0, 32'h14, 32'h0, 2, 32'hB0B0_0002, "b2b_second");
    checks++;
    if (last_rises != 1 || Read_Data_o !== 32'hB0B0_0002) begin
      errors++;
      $display("FAIL b2b_second got reqs=%0d rdata=%h want reqs=1 rdata=b0b00002", last_rises, Read_Data_o);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic        rd, wr;
    int          kind, dly;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3);
      rd = (kind == 0) || (kind == 2);
      wr = (kind == 1) || (kind == 2);
      a = $urandom;
      a[1:0] = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      dly = $urandom_range(0, 6);
      if (dly == 6) dly = -1;
      run_access(rd, wr, a, $urandom, dly, $urandom, "random");
    end
  endtask

  task automatic test_reset_mid_access();
    run_access(1'b1, 1'b0, 32'h60, 32'h0, 0, 32'h9999_0000, "pre_reset");
    @(negedge clk_i);
    MemRead_i = 1'b1; MemWrite_i = 1'b0; Addr_i = 32'h80; mem_ack_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    checks++;
    if (mem_req_o !== 1'b1) begin
      errors++;
      $display("FAIL midreset_req_before got %0b want 1", mem_req_o);
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if (mem_req_o !== 1'b0 || stall_o !== 1'b0 || Read_Data_o !== 32'd0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async got req=%0b stall=%0b rdata=%h err=%0b want 0 0 0 0",
               mem_req_o, stall_o, Read_Data_o, err_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0; MemRead_i = 1'b0;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h5A5A_5A5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      #1;
      checks++;
      if (mem_req_o !== 1'b0 || stall_o !== 1'b0 || Read_Data_o !== 32'd0) begin
        errors++;
        $display("FAIL late_ack_ignored cycle=%0d got req=%0b stall=%0b rdata=%h want 0 0 0",
                 i, mem_req_o, stall_o, Read_Data_o);
      end
    end
    mem_ack_i = 1'b0;
    rd_exp = 32'd0;
    err_exp = 1'b0;
    run_access(1'b1, 1'b0, 32'h84, 32'h0, 1, 32'h0F0F_F0F0, "post_reset");
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
